// File: rtl/sr_bank_pkg.sv
// ----------------------------------------------------------------------------
// sr_bank_pkg
// Shared constants and helpers for the SR flip-flop bank.
//   MODE_*          : resolution applied when a channel sees S=R=1
//   MAX_*           : legal upper bounds of the bank parameters
//   mode_is_legal() : range check of the MODE parameter
//   resolve_bit()   : next Q of one channel from (Q, S, R, MODE)
// ----------------------------------------------------------------------------
package sr_bank_pkg;

    localparam int MODE_SET_DOM = 0;  // S=R=1 -> Q=1
    localparam int MODE_RST_DOM = 1;  // S=R=1 -> Q=0
    localparam int MODE_HOLD    = 2;  // S=R=1 -> Q unchanged
    localparam int MODE_TOGGLE  = 3;  // S=R=1 -> Q=~Q (JK behaviour)

    localparam int MAX_WIDTH       = 32;
    localparam int MAX_SYNC_STAGES = 3;

    function automatic bit mode_is_legal(input int mode);
        return (mode >= MODE_SET_DOM) && (mode <= MODE_TOGGLE);
    endfunction

    function automatic logic resolve_bit(input logic q, input logic s,
                                         input logic r, input int mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_SET_DOM: nxt = 1'b1;
                    MODE_RST_DOM: nxt = 1'b0;
                    MODE_TOGGLE:  nxt = ~q;
                    default:      nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_sync_stage.sv
// ----------------------------------------------------------------------------
// sr_sync_stage
// WIDTH-wide, STAGES-deep shift-register synchroniser with synchronous reset.
// STAGES=0 degenerates to a straight wire.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears every stage
//   d_i   : raw input vector
//   q_o   : output of the last stage
// ----------------------------------------------------------------------------
module sr_sync_stage #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [STAGES];

        always_ff @(posedge clk) begin
            // NOTE: the whole stage array is reset, not just the last stage,
            // so a reset discards every request still in flight.
            if (reset) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < STAGES; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[STAGES-1];
    end

endmodule

// File: rtl/sr_flipflop_bank.sv
// ----------------------------------------------------------------------------
// sr_flipflop_bank
// WIDTH independent SR flip-flops behind an optional input synchroniser, with
// configurable S=R=1 resolution and conflict monitoring.
//   clk            : rising-edge clock, the only clock
//   reset          : synchronous active-high reset (Q=INIT, flags/count=0)
//   en             : apply the synchronised S/R on this edge
//   S, R           : per-channel set / reset requests
//   clr_flags      : clears conflict_flag and conflict_count
//   Q, Qbar        : registered channel state and its complement
//   conflict_flag  : sticky per-channel S=R=1 indicator
//   conflict_count : saturating count of enabled edges with any conflict
// ----------------------------------------------------------------------------
module sr_flipflop_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               MODE        = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] conflict_flag,
    output logic [CNT_W-1:0] conflict_count
);

    if (!mode_is_legal(MODE) || (WIDTH < 1) || (WIDTH > MAX_WIDTH) ||
        (SYNC_STAGES < 0) || (SYNC_STAGES > MAX_SYNC_STAGES) || (CNT_W < 1))
    begin : g_param_check
        $error("sr_flipflop_bank: illegal WIDTH/MODE/SYNC_STAGES/CNT_W");
    end

    logic [WIDTH-1:0] s_sync;
    logic [WIDTH-1:0] r_sync;

    sr_sync_stage #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_s (
        .clk   (clk),
        .reset (reset),
        .d_i   (S),
        .q_o   (s_sync)
    );

    sr_sync_stage #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_r (
        .clk   (clk),
        .reset (reset),
        .d_i   (R),
        .q_o   (r_sync)
    );

    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] flag_q,  flag_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] conflict;

    always_comb begin
        // NOTE: every variable gets its default first, so no path through
        // this block can leave one unassigned and infer a latch.
        q_d      = q_q;
        flag_d   = flag_q;
        count_d  = count_q;
        conflict = s_sync & r_sync;

        // Clear before accumulating: a conflict on the clearing edge survives.
        if (clr_flags) begin
            flag_d  = '0;
            count_d = '0;
        end

        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                q_d[i] = resolve_bit(q_q[i], s_sync[i], r_sync[i], MODE);
            end
            flag_d = flag_d | conflict;
            // One increment per edge regardless of how many channels collide.
            if ((|conflict) && (count_d != {CNT_W{1'b1}})) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            q_q     <= INIT;
            flag_q  <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign Q              = q_q;
    assign Qbar           = ~q_q;
    assign conflict_flag  = flag_q;
    assign conflict_count = count_q;

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// ----------------------------------------------------------------------------
// tb_sr_flipflop_bank
// Seven bank instances share one stimulus stream:
//   main  : SYNC_STAGES=2, INIT=0101, MODE set-dominant
//   mode0..3 : SYNC_STAGES=0, INIT=0011, one per MODE
//   sat   : SYNC_STAGES=0, CNT_W=3
//   deep  : SYNC_STAGES=3, INIT=0
// Each test builds a stimulus table, queues the expected outputs with the
// cycle they are due, and pops/compares them as the edges go by.
// ----------------------------------------------------------------------------
module tb_sr_flipflop_bank;
    import sr_bank_pkg::*;

    localparam int W      = 4;
    localparam int I_MAIN = 0;
    localparam int I_M0   = 1;  // I_M0 + MODE
    localparam int I_SAT  = 5;
    localparam int I_DEEP = 6;

    typedef enum int {F_Q, F_QBAR, F_FLAG, F_CNT} field_e;

    typedef struct {
        string      name;
        int         inst;
        field_e     fld;
        logic [7:0] exp;
        int         due;
    } exp_t;

    typedef struct {
        logic         rst;
        logic         en;
        logic         clr;
        logic [W-1:0] s;
        logic [W-1:0] r;
    } stim_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         clr_flags;
    logic [W-1:0] s_in;
    logic [W-1:0] r_in;

    logic [W-1:0] q_main, qbar_main, flag_main;
    logic [7:0]   cnt_main;
    logic [W-1:0] q_mode [4];
    logic [W-1:0] qbar_mode [4];
    logic [W-1:0] flag_mode [4];
    logic [7:0]   cnt_mode [4];
    logic [W-1:0] q_sat, qbar_sat, flag_sat;
    logic [2:0]   cnt_sat;
    logic [W-1:0] q_deep, qbar_deep, flag_deep;
    logic [7:0]   cnt_deep;

    always #5 clk = ~clk;

    sr_flipflop_bank #(.WIDTH(W), .MODE(MODE_SET_DOM), .SYNC_STAGES(2),
                       .INIT(4'b0101), .CNT_W(8)) u_main (
        .clk(clk), .reset(reset), .en(en), .S(s_in), .R(r_in),
        .clr_flags(clr_flags), .Q(q_main), .Qbar(qbar_main),
        .conflict_flag(flag_main), .conflict_count(cnt_main)
    );

    for (genvar m = 0; m < 4; m++) begin : g_mode
        sr_flipflop_bank #(.WIDTH(W), .MODE(m), .SYNC_STAGES(0),
                           .INIT(4'b0011), .CNT_W(8)) u_dut (
            .clk(clk), .reset(reset), .en(en), .S(s_in), .R(r_in),
            .clr_flags(clr_flags), .Q(q_mode[m]), .Qbar(qbar_mode[m]),
            .conflict_flag(flag_mode[m]), .conflict_count(cnt_mode[m])
        );
    end

    sr_flipflop_bank #(.WIDTH(W), .MODE(MODE_SET_DOM), .SYNC_STAGES(0),
                       .INIT(4'b0000), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .en(en), .S(s_in), .R(r_in),
        .clr_flags(clr_flags), .Q(q_sat), .Qbar(qbar_sat),
        .conflict_flag(flag_sat), .conflict_count(cnt_sat)
    );

    sr_flipflop_bank #(.WIDTH(W), .MODE(MODE_SET_DOM), .SYNC_STAGES(3),
                       .INIT(4'b0000), .CNT_W(8)) u_deep (
        .clk(clk), .reset(reset), .en(en), .S(s_in), .R(r_in),
        .clr_flags(clr_flags), .Q(q_deep), .Qbar(qbar_deep),
        .conflict_flag(flag_deep), .conflict_count(cnt_deep)
    );

    function automatic logic [7:0] observe(input int inst, input field_e f);
        logic [W-1:0] q, qb, fl;
        logic [7:0]   c;
        case (inst)
            I_MAIN:  begin q = q_main; qb = qbar_main; fl = flag_main; c = cnt_main; end
            I_SAT:   begin q = q_sat;  qb = qbar_sat;  fl = flag_sat;  c = {5'b0, cnt_sat}; end
            I_DEEP:  begin q = q_deep; qb = qbar_deep; fl = flag_deep; c = cnt_deep; end
            default: begin
                q  = q_mode[2'(inst - I_M0)];
                qb = qbar_mode[2'(inst - I_M0)];
                fl = flag_mode[2'(inst - I_M0)];
                c  = cnt_mode[2'(inst - I_M0)];
            end
        endcase
        case (f)
            F_Q:     return {4'b0, q};
            F_QBAR:  return {4'b0, qb};
            F_FLAG:  return {4'b0, fl};
            default: return c;
        endcase
    endfunction

    function automatic stim_t st(input logic rst, input logic e, input logic clr,
                                 input logic [W-1:0] s, input logic [W-1:0] r);
        stim_t x;
        x.rst = rst; x.en = e; x.clr = clr; x.s = s; x.r = r;
        return x;
    endfunction

    // Keeps the scoreboard ordered by due cycle.
    task automatic expect_at(input string name, input int inst, input field_e fld,
                             input logic [7:0] exp, input int due);
        exp_t e;
        int   idx;
        e.name = name; e.inst = inst; e.fld = fld; e.exp = exp; e.due = due;
        idx = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].due > due) begin
                idx = k;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic drive(input stim_t x);
        reset     = x.rst;
        en        = x.en;
        clr_flags = x.clr;
        s_in      = x.s;
        r_in      = x.r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        // Reset held with every other input active, then released idle.
        repeat (3) seq.push_back(st(1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111));
        seq.push_back(st(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        expect_at("rst_q_main_e1",    I_MAIN, F_Q,    8'h05, base + 1);
        expect_at("rst_qbar_main_e2", I_MAIN, F_QBAR, 8'h0A, base + 2);
        expect_at("rst_q_main_e3",    I_MAIN, F_Q,    8'h05, base + 3);
        expect_at("rst_flag_main_e3", I_MAIN, F_FLAG, 8'h00, base + 3);
        expect_at("rst_cnt_main_e3",  I_MAIN, F_CNT,  8'h00, base + 3);
        expect_at("rst_q_mode0_e3",   I_M0,   F_Q,    8'h03, base + 3);
        expect_at("rst_q_mode3_e3",   I_M0+3, F_Q,    8'h03, base + 3);
        expect_at("rst_qbar_mode1",   I_M0+1, F_QBAR, 8'h0C, base + 3);
        expect_at("rst_cnt_sat_e3",   I_SAT,  F_CNT,  8'h00, base + 3);
        expect_at("rst_q_deep_e3",    I_DEEP, F_Q,    8'h00, base + 3);
        expect_at("rst_q_main_rel",   I_MAIN, F_Q,    8'h05, base + 4);
        expect_at("rst_q_mode0_rel",  I_M0,   F_Q,    8'h03, base + 4);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000));   // edge 4 = n
        repeat (3) seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
        expect_at("lat_q_n",      I_MAIN, F_Q,    8'h05, base + 4);
        expect_at("lat_q_n1",     I_MAIN, F_Q,    8'h05, base + 5);
        expect_at("lat_q_n2",     I_MAIN, F_Q,    8'h0D, base + 6);
        expect_at("lat_qbar_n2",  I_MAIN, F_QBAR, 8'h02, base + 6);
        expect_at("lat_q_n3",     I_MAIN, F_Q,    8'h0D, base + 7);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Plain set/reset on mixed channels: channels must act independently.
    task automatic test_set_reset();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b1100, 4'b0011));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0100));
        repeat (2) seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
        for (int m = 0; m < 4; m++) begin
            expect_at($sformatf("sr_q_mode%0d_e3", m), I_M0 + m, F_Q, 8'h0C, base + 3);
            expect_at($sformatf("sr_q_mode%0d_e4", m), I_M0 + m, F_Q, 8'h0A, base + 4);
        end
        expect_at("sr_flag_mode0_e4", I_M0,   F_FLAG, 8'h00, base + 4);
        expect_at("sr_cnt_mode3_e4",  I_M0+3, F_CNT,  8'h00, base + 4);
        expect_at("sr_q_mode2_hold",  I_M0+2, F_Q,    8'h0A, base + 5);
        expect_at("sr_q_main_e5",     I_MAIN, F_Q,    8'h0C, base + 5);
        expect_at("sr_q_main_e6",     I_MAIN, F_Q,    8'h0A, base + 6);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_modes();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        logic [7:0] mode_q [4];
        int base = cycle;
        mode_q[0] = 8'h0F; mode_q[1] = 8'h00; mode_q[2] = 8'h03; mode_q[3] = 8'h0C;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111));   // one conflict edge
        seq.push_back(st(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
        for (int m = 0; m < 4; m++) begin
            expect_at($sformatf("mode%0d_q", m),    I_M0 + m, F_Q,    mode_q[m], base + 3);
            expect_at($sformatf("mode%0d_flag", m), I_M0 + m, F_FLAG, 8'h0F,     base + 3);
            expect_at($sformatf("mode%0d_cnt", m),  I_M0 + m, F_CNT,  8'h01,     base + 3);
            expect_at($sformatf("mode%0d_q_after", m), I_M0 + m, F_Q, mode_q[m], base + 5);
        end
        expect_at("mode3_cnt_after", I_M0+3, F_CNT,  8'h01, base + 5);
        expect_at("mode_main_cnt",   I_MAIN, F_CNT,  8'h01, base + 5);
        expect_at("mode_main_q",     I_MAIN, F_Q,    8'h0F, base + 5);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        repeat (2) seq.push_back(st(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111));
        repeat (3) seq.push_back(st(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000));   // edge 8
        seq.push_back(st(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        for (int k = 3; k <= 7; k++) begin
            expect_at($sformatf("en_q_main_e%0d", k), I_MAIN, F_Q, 8'h05, base + k);
        end
        expect_at("en_cnt_main_e4",  I_MAIN, F_CNT,  8'h00, base + 4);
        expect_at("en_flag_main_e7", I_MAIN, F_FLAG, 8'h00, base + 7);
        expect_at("en_cnt_main_e7",  I_MAIN, F_CNT,  8'h00, base + 7);
        expect_at("en_q_mode0_e4",   I_M0,   F_Q,    8'h03, base + 4);
        expect_at("en_cnt_mode0_e4", I_M0,   F_CNT,  8'h00, base + 4);
        expect_at("en_q_main_on",    I_MAIN, F_Q,    8'h0F, base + 8);
        expect_at("en_cnt_main_on",  I_MAIN, F_CNT,  8'h00, base + 8);
        expect_at("en_q_mode0_on",   I_M0,   F_Q,    8'h0F, base + 8);
        expect_at("en_q_main_off",   I_MAIN, F_Q,    8'h0F, base + 9);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // main has two sync stages: S/R driven at edge k is applied at edge k+2.
    task automatic test_clear_collision();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        repeat (5) seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111)); // edges 3-7
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0100, 4'b0100));            // edge 8
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));            // edge 9
        seq.push_back(st(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000));            // edge 10
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));            // edge 11
        expect_at("clr_cnt_first",   I_MAIN, F_CNT,  8'd1,  base + 5);
        expect_at("clr_flag_before", I_MAIN, F_FLAG, 8'h0F, base + 9);
        expect_at("clr_cnt_before",  I_MAIN, F_CNT,  8'd5,  base + 9);
        expect_at("clr_flag_coll",   I_MAIN, F_FLAG, 8'h04, base + 10);
        expect_at("clr_cnt_coll",    I_MAIN, F_CNT,  8'd1,  base + 10);
        expect_at("clr_q_untouched", I_MAIN, F_Q,    8'h0F, base + 10);
        expect_at("clr_flag_after",  I_MAIN, F_FLAG, 8'h04, base + 11);
        expect_at("clr_cnt_after",   I_MAIN, F_CNT,  8'd1,  base + 11);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturation();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        repeat (10) seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111));
        seq.push_back(st(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000));
        for (int k = 1; k <= 10; k++) begin
            expect_at($sformatf("sat_cnt_%0d", k), I_SAT, F_CNT,
                      8'((k > 7) ? 7 : k), base + 2 + k);
        end
        expect_at("sat_cnt_hold", I_SAT, F_CNT, 8'd7, base + 13);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // deep has three sync stages; a reset must flush the request from edge 3,
    // and the next request (edge 10) must still take three edges.
    task automatic test_reset_midpipe();
        stim_t seq[$];
        exp_t  e;
        logic [7:0] obs;
        int base = cycle;
        repeat (2) seq.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000));   // edge 3 = n
        seq.push_back(st(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000));   // edge 4 reset
        repeat (5) seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
        seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000));   // edge 10 = m
        repeat (4) seq.push_back(st(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000));
        for (int k = 3; k <= 12; k++) begin
            expect_at($sformatf("mid_q_deep_e%0d", k), I_DEEP, F_Q, 8'h00, base + k);
        end
        expect_at("mid_q_deep_m3", I_DEEP, F_Q, 8'h02, base + 13);
        expect_at("mid_q_deep_m4", I_DEEP, F_Q, 8'h02, base + 14);
        foreach (seq[j]) begin
            drive(seq[j]);
            tick();
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                obs = observe(e.inst, e.fld);
                vectors++;
                if (obs !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): observed %b, expected %b", e.name, cycle, obs, e.exp);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        clr_flags = 1'b0;
        s_in      = '0;
        r_in      = '0;

        test_reset();
        test_latency();
        test_set_reset();
        test_modes();
        test_enable();
        test_clear_collision();
        test_saturation();
        test_reset_midpipe();

        // Anything still queued was never reached.
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never compared (due cycle %0d, ended at %0d)", e.name, e.due, cycle);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule
